// File: rtl/memtrace_pkg.sv
// Shared types for the memory-trace path: per-lane request layout and field widths.
// Kept free of lane-count parameters so the trace-reader wrapper can import it too.
package memtrace_pkg;

    localparam int ADDR_WIDTH    = 64;
    localparam int DATA_WIDTH    = 64;
    localparam int LOGSIZE_WIDTH = 32;
    localparam int MAX_LOGSIZE   = 3;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0]    address;
        logic                     is_store;
        logic [LOGSIZE_WIDTH-1:0] size;
        logic [DATA_WIDTH-1:0]    data;
    } mem_req_t;

    // Accesses wider than 8 bytes cannot be expressed on the request channel.
    function automatic logic size_illegal(input logic [LOGSIZE_WIDTH-1:0] size);
        return size > LOGSIZE_WIDTH'(MAX_LOGSIZE);
    endfunction

endpackage

// File: rtl/memtrace_lane_dispatcher_if.sv
// Trace-beat input, per-lane request output and response pulses of the dispatcher.
// master = environment (trace reader + memory), slave = dispatcher.
interface memtrace_lane_dispatcher_if
    import memtrace_pkg::*;
#(
    parameter int NUM_LANES = 4
);

    logic                               trace_read_ready;
    logic [NUM_LANES-1:0]               trace_read_valid;
    logic [ADDR_WIDTH*NUM_LANES-1:0]    trace_read_address;
    logic [NUM_LANES-1:0]               trace_read_is_store;
    logic [LOGSIZE_WIDTH*NUM_LANES-1:0] trace_read_size;
    logic [DATA_WIDTH*NUM_LANES-1:0]    trace_read_data;
    logic                               trace_read_finished;

    logic [NUM_LANES-1:0]               req_valid;
    logic [NUM_LANES-1:0]               req_ready;
    logic [ADDR_WIDTH*NUM_LANES-1:0]    req_address;
    logic [NUM_LANES-1:0]               req_is_store;
    logic [LOGSIZE_WIDTH*NUM_LANES-1:0] req_size;
    logic [DATA_WIDTH*NUM_LANES-1:0]    req_data;

    logic [NUM_LANES-1:0]               resp_valid;

    modport master (
        input  trace_read_ready,
        output trace_read_valid, trace_read_address, trace_read_is_store,
        output trace_read_size, trace_read_data, trace_read_finished,
        input  req_valid, req_address, req_is_store, req_size, req_data,
        output req_ready, resp_valid
    );

    modport slave (
        output trace_read_ready,
        input  trace_read_valid, trace_read_address, trace_read_is_store,
        input  trace_read_size, trace_read_data, trace_read_finished,
        output req_valid, req_address, req_is_store, req_size, req_data,
        input  req_ready, resp_valid
    );

endinterface

// File: rtl/memtrace_lane_fifo.sv
// Single-lane request FIFO with occupancy count; head is presented combinationally
// and forced to zero while empty so idle request fields read as 0.
module memtrace_lane_fifo
    import memtrace_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   push,
    input  mem_req_t               push_data,
    input  logic                   pop,
    output mem_req_t               head,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PTR_W = $clog2(DEPTH);

    mem_req_t             mem [DEPTH];
    logic [PTR_W-1:0]     wr_ptr_reg;
    logic [PTR_W-1:0]     rd_ptr_reg;
    logic [PTR_W:0]       count_reg;
    logic                 do_push;
    logic                 do_pop;

    assign do_push = push && (count_reg != (PTR_W+1)'(DEPTH));
    assign do_pop  = pop && (count_reg != '0);

    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    // Pointers are exactly log2(DEPTH) wide, so they wrap without explicit compare.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    assign empty = (count_reg == '0);
    assign count = count_reg;
    assign head  = empty ? '0 : mem[rd_ptr_reg];

endmodule

// File: rtl/memtrace_lane_dispatcher.sv
// Splits all-lanes trace beats into per-lane request streams, caps outstanding
// requests per lane, and reports a drained finish and sticky protocol errors.
module memtrace_lane_dispatcher
    import memtrace_pkg::*;
#(
    parameter int NUM_LANES    = 4,
    parameter int FIFO_DEPTH   = 4,
    parameter int MAX_INFLIGHT = 8
) (
    input  logic                        clock,
    input  logic                        reset,
    memtrace_lane_dispatcher_if.slave   bus,
    output logic                        finished,
    output logic                        error
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int INF_W = $clog2(MAX_INFLIGHT + 1);

    logic                               out_of_reset_reg;
    logic                               finished_seen_reg;
    logic                               finished_reg;
    logic                               error_reg;
    logic                               accept;

    logic [NUM_LANES-1:0]               lane_full;
    logic [NUM_LANES-1:0]               lane_empty;
    logic [NUM_LANES-1:0]               enq;
    logic [NUM_LANES-1:0]               issue;
    logic [NUM_LANES-1:0]               inflight_zero;
    logic [NUM_LANES-1:0]               lane_error;

    logic [NUM_LANES-1:0]               req_valid_w;
    logic [ADDR_WIDTH*NUM_LANES-1:0]    req_address_w;
    logic [NUM_LANES-1:0]               req_is_store_w;
    logic [LOGSIZE_WIDTH*NUM_LANES-1:0] req_size_w;
    logic [DATA_WIDTH*NUM_LANES-1:0]    req_data_w;

    // Ready is purely state-derived so the reader never sees a combinational loop.
    assign accept = out_of_reset_reg && !(|lane_full);

    for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
        mem_req_t         in_req;
        mem_req_t         head;
        logic [CNT_W-1:0] count;
        logic [INF_W-1:0] inflight_reg;

        assign in_req = {bus.trace_read_address[ADDR_WIDTH*gi +: ADDR_WIDTH],
                         bus.trace_read_is_store[gi],
                         bus.trace_read_size[LOGSIZE_WIDTH*gi +: LOGSIZE_WIDTH],
                         bus.trace_read_data[DATA_WIDTH*gi +: DATA_WIDTH]};

        assign enq[gi] = accept && bus.trace_read_valid[gi];

        memtrace_lane_fifo #(
            .DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .clock     (clock),
            .reset     (reset),
            .push      (enq[gi]),
            .push_data (in_req),
            .pop       (issue[gi]),
            .head      (head),
            .empty     (lane_empty[gi]),
            .count     (count)
        );

        assign lane_full[gi]     = (count == CNT_W'(FIFO_DEPTH));
        assign inflight_zero[gi] = (inflight_reg == '0);
        assign req_valid_w[gi]   = !lane_empty[gi] && (inflight_reg < INF_W'(MAX_INFLIGHT));
        assign issue[gi]         = req_valid_w[gi] && bus.req_ready[gi];

        assign req_address_w[ADDR_WIDTH*gi +: ADDR_WIDTH]          = head.address;
        assign req_is_store_w[gi]                                  = head.is_store;
        assign req_size_w[LOGSIZE_WIDTH*gi +: LOGSIZE_WIDTH]       = head.size;
        assign req_data_w[DATA_WIDTH*gi +: DATA_WIDTH]             = head.data;

        // A response with nothing outstanding is a protocol error, not an underflow.
        assign lane_error[gi] = (bus.resp_valid[gi] && inflight_zero[gi]) ||
                                (enq[gi] && size_illegal(in_req.size));

        always_ff @(posedge clock or negedge reset) begin
            if (!reset) begin
                inflight_reg <= '0;
            end else if (issue[gi] && !bus.resp_valid[gi]) begin
                inflight_reg <= inflight_reg + 1'b1;
            end else if (!issue[gi] && bus.resp_valid[gi] && !inflight_zero[gi]) begin
                inflight_reg <= inflight_reg - 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            out_of_reset_reg  <= 1'b0;
            finished_seen_reg <= 1'b0;
            finished_reg      <= 1'b0;
            error_reg         <= 1'b0;
        end else begin
            out_of_reset_reg <= 1'b1;
            if (bus.trace_read_finished) begin
                finished_seen_reg <= 1'b1;
            end
            if (finished_seen_reg && (&lane_empty) && (&inflight_zero)) begin
                finished_reg <= 1'b1;
            end
            if (|lane_error) begin
                error_reg <= 1'b1;
            end
        end
    end

    assign bus.trace_read_ready = accept;
    assign bus.req_valid        = req_valid_w;
    assign bus.req_address      = req_address_w;
    assign bus.req_is_store     = req_is_store_w;
    assign bus.req_size         = req_size_w;
    assign bus.req_data         = req_data_w;
    assign finished             = finished_reg;
    assign error                = error_reg;

endmodule

// File: doc/memtrace_lane_dispatcher.md
# memtrace_lane_dispatcher

Sits directly downstream of the simulated memory-trace reader and turns its all-lanes-at-once trace beats into independent per-lane memory requests. Buffers each lane's requests in a small FIFO and issues them on a per-lane valid/ready request channel. Tracks outstanding responses per lane, back-pressures the trace reader, and raises a drained `finished` once the trace has ended and every lane is idle.

## Interface
Parameters:
- NUM_LANES, 4, lane count; must match the trace reader.
- FIFO_DEPTH, 4, entries per lane FIFO; power of two, ≥2.
- MAX_INFLIGHT, 8, max issued-but-unanswered requests per lane; ≥1.

Ports:
- clock  in  1  sole clock.
- reset  in  1  asynchronous, active-low reset.
- trace_read_ready  out  1  accept a trace beat this cycle.
- trace_read_valid  in  NUM_LANES  per-lane request present in beat.
- trace_read_address  in  64*NUM_LANES  lane g at bits [64g+63:64g].
- trace_read_is_store  in  NUM_LANES  1 = store, 0 = load.
- trace_read_size  in  32*NUM_LANES  log2 bytes; lane g at [32g+31:32g].
- trace_read_data  in  64*NUM_LANES  store data.
- trace_read_finished  in  1  trace exhausted.
- req_valid  out  NUM_LANES  per-lane request valid.
- req_ready  in  NUM_LANES  per-lane request ready.
- req_address / req_is_store / req_size / req_data  out  same packing as trace_read_*  head-of-FIFO fields.
- resp_valid  in  NUM_LANES  one response per pulse; always accepted.
- finished  out  1  trace ended and all lanes drained.
- error  out  1  sticky protocol error.

## Operation
- Accept: `trace_read_ready` = out-of-reset flop AND every lane FIFO count < FIFO_DEPTH. It depends only on state, never on `trace_read_valid`.
- Enqueue lane g when `trace_read_ready && trace_read_valid[g]`. Lanes with valid=0 in an accepted beat enqueue nothing.
- Issue: `req_valid[g]` = FIFO[g] non-empty AND inflight[g] < MAX_INFLIGHT. Fields are the FIFO head. Dequeue on `req_valid[g] && req_ready[g]`. Fields stay stable while valid and not ready.
- Inflight counters are clog2(MAX_INFLIGHT+1) bits wide. Issue increments, `resp_valid` decrements, both together leave the counter unchanged.
- `resp_valid[g]` with inflight[g]==0: counter stays 0, `error` is set.
- Enqueue with size field > 3: entry is still enqueued, `error` is set.
- `finished_seen` is sticky, set when `trace_read_finished` is sampled 1 (independent of ready).
- `finished` is registered: next value = finished_seen AND all FIFOs empty AND all inflight zero. Once 1 it stays 1 until reset.

## Timing
- Reset (asserted low): FIFOs empty, inflight 0, finished_seen 0.
  - Outputs: `trace_read_ready`=0, `req_valid`=0, `req_*` fields 0, `finished`=0, `error`=0.
- First cycle after release: `trace_read_ready`=1.
- Enqueue → `req_valid` latency is 1 cycle. No same-cycle bypass.
- Full FIFO with a simultaneous dequeue: ready is still 0 that cycle, so no enqueue (no pass-through). Ready rises the following cycle.
- Simultaneous enqueue and dequeue on a non-full, non-empty FIFO: count unchanged.
- FIFO pointers are clog2(FIFO_DEPTH) bits and wrap naturally. Count is one bit wider.
- `finished` rises exactly 1 cycle after the last lane drains (empty FIFO, inflight 0) with finished_seen set. If finished_seen is set last, it rises 1 cycle after that.
- Reset mid-operation: queued entries and inflight counts are discarded immediately (asynchronous). Responses arriving later set `error`.

## Structure
- Package `memtrace_pkg`: DATA_WIDTH=64, LOGSIZE_WIDTH=32, and a packed request struct {address, is_store, size, data}. Shareable with the trace-reader wrapper.
- Sub-module `memtrace_lane_fifo`: single-lane synchronous FIFO with count. Instantiated NUM_LANES times via generate.
- Top level holds the accept logic, inflight counters, and the finished/error flops.

## Test plan
- Reset/idle: hold reset low 3 cycles → all outputs 0. Release → `trace_read_ready`=1 next cycle, `finished`=0.
- Single beat: lane 1 valid, addr 0x1000, store, size 3, data 0xDEADBEEF, `req_ready`=1 → `req_valid[1]` exactly 1 cycle later with those fields. Other lanes stay idle. inflight[1]=1 until `resp_valid[1]`.
- Backpressure: `req_ready`=0, 4 beats all lanes valid (FIFO_DEPTH=4) → ready drops to 0 after the 4th. Raise `req_ready[0..3]` for one cycle → ready returns 1 the cycle after, with no entry lost or duplicated and FIFO order preserved.
- Inflight cap: MAX_INFLIGHT=8, 9 queued requests on lane 0, no responses → 8 issued, `req_valid[0]` drops. One `resp_valid[0]` → 9th issues next cycle.
- Finish: `trace_read_finished` pulsed while lane 2 still has 2 inflight → `finished`=0. After the second `resp_valid[2]` → `finished`=1 next cycle and stays high.
- Errors: `resp_valid[3]` with inflight 0 → `error`=1 sticky. Also, separately, a beat with size 5 → `error`=1 and the entry is still issued.
